axi_rd_arbiter: RTL



---
 rtl/axi_pkg.sv | 14 +
 rtl/axi_rd_arbiter_if.sv | 57 +++++
 rtl/axi_rd_arbiter_rr_arb2.sv | 18 +
 rtl/axi_rd_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and arbiter state encoding for the core read path.
package axi_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int RD_REQ_ICACHE = 0;
    localparam int RD_REQ_DCACHE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;
endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Requester-side and AXI-read-side bundles for the read arbiter.
interface rd_req_if #(parameter int AXI_DATA_WIDTH = 128);
    logic [1:0]                req_valid;
    logic [1:0]                req_ready;
    logic [31:0]               req_addr0;
    logic [31:0]               req_addr1;
    logic [7:0]                req_len0;
    logic [7:0]                req_len1;
    logic [2:0]                req_size0;
    logic [2:0]                req_size1;
    logic [1:0]                resp_valid;
    logic [1:0]                resp_ready;
    logic [AXI_DATA_WIDTH-1:0] resp_data;
    logic                      resp_last;
    logic                      resp_err;

    modport master (
        output req_valid, req_addr0, req_addr1, req_len0, req_len1,
               req_size0, req_size1, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_last, resp_err
    );
    modport slave (
        input  req_valid, req_addr0, req_addr1, req_len0, req_len1,
               req_size0, req_size1, resp_ready,
        output req_ready, resp_valid, resp_data, resp_last, resp_err
    );
endinterface

interface axi_rd_if #(parameter int AXI_DATA_WIDTH = 128, parameter int ID_W = 4);
    logic [ID_W-1:0]           arid;
    logic [31:0]               araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic [1:0]                arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [ID_W-1:0]           rid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Combinational 2-way round-robin selector; on a tie the side that did not win last time wins.
module rr_arb2
    import axi_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant[RD_REQ_ICACHE] = 1'b1;
            2'b10:   o_grant[RD_REQ_DCACHE] = 1'b1;
            2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: one burst at a time, AR issued from latched fields, R routed to owner.
//   state   | meaning
//   ST_IDLE | waiting for a request, grant is combinational
//   ST_ADDR | AR beat presented, fields held until arready
//   ST_DATA | R beats routed to the owner until rlast handshake
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int ID_W           = 4
) (
    input  logic       aclk,
    input  logic       aresetn,
    rd_req_if.slave    req,
    axi_rd_if.master   axi
);
    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic                      r_last_grant;
    logic                      r_owner;
    logic [31:0]               r_addr;
    logic [7:0]                r_len;
    logic [2:0]                r_size;
    logic [7:0]                r_beat_cnt;
    logic [1:0]                w_grant;
    logic                      w_req_hs;
    logic                      w_beat_hs;
    logic [AXI_DATA_WIDTH-1:0] w_rdata;

    rr_arb2 u_rr_arb2 (
        .i_req   (req.req_valid),
        .i_last  (r_last_grant),
        .o_grant (w_grant)
    );

    // w_grant is already qualified by req_valid, so any set bit is a handshake
    assign w_req_hs  = (r_state == ST_IDLE) && (|w_grant);
    assign w_beat_hs = (r_state == ST_DATA) && axi.rvalid && req.resp_ready[r_owner];

    assign w_rdata       = axi.rdata;
    assign req.resp_data = w_rdata;

    assign axi.arid    = ID_W'(r_owner);
    assign axi.araddr  = r_addr;
    assign axi.arlen   = r_len;
    assign axi.arsize  = r_size;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;

    always_comb begin
        w_state_nxt    = r_state;
        req.req_ready  = 2'b00;
        req.resp_valid = 2'b00;
        req.resp_last  = 1'b0;
        req.resp_err   = 1'b0;
        axi.arvalid    = 1'b0;
        axi.rready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req.req_ready = aresetn ? w_grant : 2'b00;
                if (w_req_hs) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                axi.rready              = req.resp_ready[r_owner];
                req.resp_valid[r_owner] = axi.rvalid;
                req.resp_last           = axi.rlast;
                // rlast decides where the burst ends; a count disagreement is only flagged
                req.resp_err = (axi.rresp != AXI_RESP_OKAY) ||
                               (axi.rid != ID_W'(r_owner)) ||
                               (axi.rlast != (r_beat_cnt == r_len));
                if (w_beat_hs && axi.rlast) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b0;
            r_owner      <= 1'b0;
            r_addr       <= 32'd0;
            r_len        <= 8'd0;
            r_size       <= 3'd0;
            r_beat_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_hs) begin
                r_owner      <= w_grant[RD_REQ_DCACHE];
                r_last_grant <= w_grant[RD_REQ_DCACHE];
                r_addr       <= w_grant[RD_REQ_DCACHE] ? req.req_addr1 : req.req_addr0;
                r_len        <= w_grant[RD_REQ_DCACHE] ? req.req_len1  : req.req_len0;
                r_size       <= w_grant[RD_REQ_DCACHE] ? req.req_size1 : req.req_size0;
                r_beat_cnt   <= 8'd0;
            end else if (w_beat_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end
endmodule
